cpu_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute controller for the 4-bit accumulator CPU.
- Replaces the free-running one-instruction-per-clock flow: latches the instruction into an internal IR, sequences the PC, accumulator and ALU strobes, and supports run, single-step, stop and halt.
- Sits between instruction memory and the pc/accumulator/alu instances inside the CPU top level.

---
 rtl/cpu_pkg.sv | 57 +++++
 rtl/cpu_seq_decode.sv | 28 ++
 rtl/cpu_sequencer.sv | 178 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU sequencer: opcodes, FSM states,
// decode flags and the execute-stage strobe bundle.
package cpu_pkg;

    localparam int PC_WIDTH_DEF  = 4;
    localparam int OP_WIDTH_DEF  = 4;
    localparam int CNT_WIDTH_DEF = 8;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    typedef struct packed {
        logic ld;
        logic alu;
        logic jmp;
        logic jz;
        logic hlt;
    } dec_flags_t;

    typedef struct packed {
        logic pc_inc;
        logic jump;
        logic load_acc;
        logic alu_enable;
    } strobe_t;

    // Anything that neither jumps nor halts advances the PC.
    function automatic strobe_t exec_strobes(input dec_flags_t f, input logic acc_zero);
        strobe_t s;
        s = '0;
        if (f.jmp || (f.jz && acc_zero)) begin
            s.jump = 1'b1;
        end else if (!f.hlt) begin
            s.pc_inc = 1'b1;
        end
        s.load_acc   = f.ld;
        s.alu_enable = f.alu;
        return s;
    endfunction

endpackage

// File: rtl/cpu_seq_decode.sv
// Combinational opcode classifier for the CPU sequencer; unlisted opcodes
// produce no flags and therefore behave as NOP.
module cpu_seq_decode
    import cpu_pkg::*;
#(
    parameter int OP_WIDTH = OP_WIDTH_DEF
) (
    input  logic [OP_WIDTH-1:0] opcode,
    output dec_flags_t          flags
);

    always_comb begin
        flags = '0;
        case (opcode)
            OP_WIDTH'(OP_LDI): flags.ld  = 1'b1;
            OP_WIDTH'(OP_ADD),
            OP_WIDTH'(OP_SUB),
            OP_WIDTH'(OP_AND),
            OP_WIDTH'(OP_OR),
            OP_WIDTH'(OP_XOR): flags.alu = 1'b1;
            OP_WIDTH'(OP_JMP): flags.jmp = 1'b1;
            OP_WIDTH'(OP_JZ):  flags.jz  = 1'b1;
            OP_WIDTH'(OP_HLT): flags.hlt = 1'b1;
            default:           flags     = '0;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller for the 4-bit accumulator CPU with run, step,
// stop and halt. Define CPU_SEQ_BREAKPOINT_EN to add the PC breakpoint ports.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH  = PC_WIDTH_DEF,
    parameter int OP_WIDTH  = OP_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  step,
    input  logic                  stop,
    input  logic [2*OP_WIDTH-1:0] instruction,
    input  logic [PC_WIDTH-1:0]   pc_in,
    input  logic                  acc_zero,
`ifdef CPU_SEQ_BREAKPOINT_EN
    input  logic                  bp_valid,
    input  logic [PC_WIDTH-1:0]   bp_addr,
    output logic                  bp_hit,
`endif
    output logic                  pc_inc,
    output logic                  jump,
    output logic [PC_WIDTH-1:0]   jump_addr,
    output logic [OP_WIDTH-1:0]   ir_opcode,
    output logic [OP_WIDTH-1:0]   ir_operand,
    output logic                  load_acc,
    output logic                  alu_enable,
    output logic                  busy,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  retired
);

    state_t                state_q, state_d;
    logic                  run_mode_q, run_mode_d;
    logic                  stop_q, stop_d;
    logic                  ir_load;
    logic [2*OP_WIDTH-1:0] ir_q;
    strobe_t               strobe_q, strobe_d;
    logic [CNT_WIDTH-1:0]  retired_q;
    dec_flags_t            flags;
    logic                  in_busy;
    logic                  bp_stop;

`ifdef CPU_SEQ_BREAKPOINT_EN
    logic bp_hit_q, bp_hit_d;

    // Breakpoints only interrupt free-run so a step can execute the flagged instruction.
    assign bp_stop = run_mode_q && bp_valid && (pc_in == bp_addr);
`else
    logic unused_pc;

    assign bp_stop   = 1'b0;
    assign unused_pc = ^pc_in;
`endif

    cpu_seq_decode #(
        .OP_WIDTH (OP_WIDTH)
    ) u_decode (
        .opcode (ir_q[2*OP_WIDTH-1:OP_WIDTH]),
        .flags  (flags)
    );

    assign in_busy = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXECUTE);

    always_comb begin
        state_d    = state_q;
        run_mode_d = run_mode_q;
        stop_d     = stop_q;
        ir_load    = 1'b0;
        strobe_d   = '0;
`ifdef CPU_SEQ_BREAKPOINT_EN
        bp_hit_d   = bp_hit_q;
`endif

        if (stop && in_busy) begin
            stop_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start || step) begin
                    state_d    = S_FETCH;
                    run_mode_d = start;
                    stop_d     = stop;
`ifdef CPU_SEQ_BREAKPOINT_EN
                    bp_hit_d   = 1'b0;
`endif
                end
            end
            S_FETCH: begin
                if (bp_stop) begin
                    state_d    = S_IDLE;
                    run_mode_d = 1'b0;
                    stop_d     = 1'b0;
`ifdef CPU_SEQ_BREAKPOINT_EN
                    bp_hit_d   = 1'b1;
`endif
                end else begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Strobes are registered here so they are valid for exactly the EXECUTE cycle.
                strobe_d = exec_strobes(flags, acc_zero);
                state_d  = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (flags.hlt) begin
                    state_d    = S_HALT;
                    run_mode_d = 1'b0;
                end else if (run_mode_q && !stop_q && !stop) begin
                    state_d = S_FETCH;
                end else begin
                    state_d    = S_IDLE;
                    run_mode_d = 1'b0;
                    stop_d     = 1'b0;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d    = S_IDLE;
                run_mode_d = 1'b0;
                stop_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            run_mode_q <= 1'b0;
            stop_q     <= 1'b0;
            ir_q       <= '0;
            strobe_q   <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            run_mode_q <= run_mode_d;
            stop_q     <= stop_d;
            strobe_q   <= strobe_d;
            if (ir_load) begin
                ir_q <= instruction;
            end
            if (state_q == S_EXECUTE) begin
                retired_q <= retired_q + CNT_WIDTH'(1);
            end
        end
    end

`ifdef CPU_SEQ_BREAKPOINT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bp_hit_q <= 1'b0;
        end else begin
            bp_hit_q <= bp_hit_d;
        end
    end

    assign bp_hit = bp_hit_q;
`endif

    assign ir_opcode  = ir_q[2*OP_WIDTH-1:OP_WIDTH];
    assign ir_operand = ir_q[OP_WIDTH-1:0];
    assign jump_addr  = PC_WIDTH'(ir_q[OP_WIDTH-1:0]);
    assign pc_inc     = strobe_q.pc_inc;
    assign jump       = strobe_q.jump;
    assign load_acc   = strobe_q.load_acc;
    assign alu_enable = strobe_q.alu_enable;
    assign busy       = in_busy;
    assign halted     = (state_q == S_HALT);
    assign retired    = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: an instruction-level program interpreter
// predicts every executed instruction; a monitor checks each EXECUTE cycle.
module tb_cpu_sequencer;

    logic       clk;
    logic       reset;
    logic       start, step, stop;
    logic [7:0] instruction;
    logic [3:0] pc_in;
    logic       acc_zero;
    logic       pc_inc, jump, load_acc, alu_enable, busy, halted;
    logic [3:0] jump_addr, ir_opcode, ir_operand;
    logic [7:0] retired;
`ifdef CPU_SEQ_BREAKPOINT_EN
    logic       bp_valid;
    logic [3:0] bp_addr;
    logic       bp_hit;
`endif

    cpu_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .step        (step),
        .stop        (stop),
        .instruction (instruction),
        .pc_in       (pc_in),
        .acc_zero    (acc_zero),
`ifdef CPU_SEQ_BREAKPOINT_EN
        .bp_valid    (bp_valid),
        .bp_addr     (bp_addr),
        .bp_hit      (bp_hit),
`endif
        .pc_inc      (pc_inc),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .ir_opcode   (ir_opcode),
        .ir_operand  (ir_operand),
        .load_acc    (load_acc),
        .alu_enable  (alu_enable),
        .busy        (busy),
        .halted      (halted),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] alu(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            4'h2:    return a + b;
            4'h3:    return a - b;
            4'h4:    return a & b;
            4'h5:    return a | b;
            4'h6:    return a ^ b;
            default: return a;
        endcase
    endfunction

    // Surrounding CPU: program memory, PC block and accumulator driven by the strobes.
    logic [7:0] prog [16];
    logic [3:0] env_pc, env_acc;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            env_pc  <= 4'd0;
            env_acc <= 4'd0;
        end else begin
            if (jump) env_pc <= jump_addr;
            else if (pc_inc) env_pc <= env_pc + 4'd1;
            if (load_acc) env_acc <= ir_operand;
            else if (alu_enable) env_acc <= alu(ir_opcode, env_acc, ir_operand);
        end
    end

    assign instruction = prog[env_pc];
    assign pc_in       = env_pc;
    assign acc_zero    = (env_acc == 4'd0);

    // Reference: architectural interpreter; strb = {pc_inc, jump, load_acc, alu_enable}.
    typedef struct packed {
        logic [3:0] op;
        logic [3:0] opnd;
        logic [3:0] strb;
    } exp_t;

    exp_t       exp_q [$];
    logic [3:0] m_pc, m_acc;
    logic [7:0] m_retired;
    bit         m_halted, m_bp_hit;

    task automatic model_reset();
        m_pc = 4'd0; m_acc = 4'd0; m_retired = 8'd0; m_halted = 1'b0; m_bp_hit = 1'b0;
    endtask

    task automatic model_run(input bit run_mode, input int n_max);
        exp_t       e;
        logic [7:0] w;
        int         lim;
        lim = run_mode ? n_max : 1;
        for (int k = 0; k < lim; k++) begin
            if (m_halted) break;
`ifdef CPU_SEQ_BREAKPOINT_EN
            if (run_mode && bp_valid && m_pc == bp_addr) begin
                m_bp_hit = 1'b1;
                break;
            end
`endif
            w = prog[m_pc];
            e.op = w[7:4];
            e.opnd = w[3:0];
            case (e.op)
                4'h1: begin e.strb = 4'b1010; m_acc = e.opnd; m_pc = m_pc + 4'd1; end
                4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                    e.strb = 4'b1001; m_acc = alu(e.op, m_acc, e.opnd); m_pc = m_pc + 4'd1;
                end
                4'h7: begin e.strb = 4'b0100; m_pc = e.opnd; end
                4'h8: begin
                    if (m_acc == 4'd0) begin e.strb = 4'b0100; m_pc = e.opnd; end
                    else begin e.strb = 4'b1000; m_pc = m_pc + 4'd1; end
                end
                4'hF: begin e.strb = 4'b0000; m_halted = 1'b1; end
                default: begin e.strb = 4'b1000; m_pc = m_pc + 4'd1; end
            endcase
            m_retired = m_retired + 8'd1;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: busy cycles come in FETCH/DECODE/EXECUTE triples; every third is EXECUTE.
    int   busy_cnt = 0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (!reset) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            else busy_cnt = 0;
            if (busy && (busy_cnt % 3 == 0)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_exec", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("exec_strobes", {pc_inc, jump, load_acc, alu_enable}, mon_e.strb);
                    check("exec_opcode", ir_opcode, mon_e.op);
                    check("exec_operand", ir_operand, mon_e.opnd);
                    if (mon_e.strb[2]) check("exec_jump_addr", jump_addr, mon_e.opnd);
                end
            end else begin
                check("quiet_strobes", {pc_inc, jump, load_acc, alu_enable}, 4'b0000);
            end
        end
    end

    task automatic apply_reset();
        reset = 1'b0;
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic do_start(input int stop_at);
        int n;
        if (!m_halted) begin
            m_bp_hit = 1'b0;
            if (stop_at < 0) n = 200;
            else if (stop_at == 0) n = 1;
            else n = (stop_at - 1) / 3 + 1;
            model_run(1'b1, n);
        end
        start = 1'b1;
        stop  = (stop_at == 0);
        @(posedge clk);
        #1 start = 1'b0;
        stop = 1'b0;
        for (int t = 1; t <= stop_at; t++) begin
            stop = (t == stop_at);
            @(posedge clk);
            #1 stop = 1'b0;
        end
    endtask

    task automatic do_step();
        if (!m_halted) begin
            m_bp_hit = 1'b0;
            model_run(1'b0, 1);
        end
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 32'(n >= 500), 32'd0);
    endtask

    task automatic post_check(input string name);
        check({name, "_retired"}, retired, m_retired);
        check({name, "_halted"}, halted, 32'(m_halted));
        check({name, "_busy"}, busy, 32'd0);
        check({name, "_pending"}, exp_q.size(), 32'd0);
`ifdef CPU_SEQ_BREAKPOINT_EN
        check({name, "_bp_hit"}, bp_hit, 32'(m_bp_hit));
`endif
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; step = 1'b0; stop = 1'b0;
`ifdef CPU_SEQ_BREAKPOINT_EN
        bp_valid = 1'b0; bp_addr = 4'd0;
`endif
        clear_prog();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 32'd0);
        check("rst_halted", halted, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_strobes", {pc_inc, jump, load_acc, alu_enable}, 32'd0);
        check("rst_ir", {ir_opcode, ir_operand}, 32'd0);
        reset = 1'b1;

        // Single step of LDI 3
        prog[0] = 8'h13;
        do_step();
        wait_done("t1");
        post_check("t1");

        // Free run to HLT, then start/step must be ignored
        apply_reset();
        prog[0] = 8'h15; prog[1] = 8'h22; prog[2] = 8'hF0;
        do_start(-1);
        wait_done("t2");
        post_check("t2");
        do_start(-1);
        repeat (6) @(negedge clk);
        post_check("t2_start_ignored");
        do_step();
        repeat (6) @(negedge clk);
        post_check("t2_step_ignored");

        // JZ taken with ACC == 0, then not taken with ACC != 0
        apply_reset();
        clear_prog();
        prog[0] = 8'h86;
        do_step();
        wait_done("t3a");
        post_check("t3a");
        apply_reset();
        prog[0] = 8'h11; prog[1] = 8'h86;
        do_step();
        wait_done("t3b0");
        do_step();
        wait_done("t3b");
        post_check("t3b");

        // Stop during DECODE of the second instruction
        apply_reset();
        clear_prog();
        do_start(5);
        wait_done("t4");
        post_check("t4");

        // Asynchronous reset in the EXECUTE cycle of JMP 2
        apply_reset();
        prog[0] = 8'h72;
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 check("t5_jump_before", jump, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("t5_strobes", {pc_inc, jump, load_acc, alu_enable}, 32'd0);
        check("t5_retired", retired, 32'd0);
        check("t5_busy", busy, 32'd0);
        check("t5_halted", halted, 32'd0);
        check("t5_ir", {ir_opcode, ir_operand}, 32'd0);
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;

`ifdef CPU_SEQ_BREAKPOINT_EN
        // Breakpoint at PC 2, then a step runs the flagged instruction
        apply_reset();
        clear_prog();
        bp_valid = 1'b1;
        bp_addr  = 4'd2;
        do_start(-1);
        wait_done("t6");
        post_check("t6");
        do_step();
        wait_done("t6_step");
        post_check("t6_step");
        bp_valid = 1'b0;
`endif

        // Randomized programs with random step / run-and-stop
        apply_reset();
        for (int it = 0; it < 30; it++) begin
            if (m_halted) apply_reset();
            for (int i = 0; i < 16; i++) begin
                logic [3:0] op;
                op = 4'($urandom_range(0, 15));
                if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h0;
                prog[i] = {op, 4'($urandom_range(0, 15))};
            end
            if ($urandom_range(0, 2) == 0) do_step();
            else do_start(int'($urandom_range(0, 40)));
            wait_done("rand");
            post_check("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
